// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and defaults for the set-associative tag store
package cache_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  localparam int DEF_SETS  = 1024;
  localparam int DEF_WAYS  = 2;
  localparam int DEF_TAG_W = 18;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
  } cache_tag_type;

endpackage

// File: rtl/cache_tag_way_ram.sv
// rtl/cache_tag_way_ram.sv - one way of tag storage, synchronous read-first RAM
module cache_tag_way_ram
  import cache_pkg::*;
#(
  parameter int DEPTH = DEF_SETS,
  parameter int DW    = DEF_TAG_W + 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are not reset; the sweep FSM in the top level clears them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_tag_array.sv
// rtl/cache_tag_array.sv - N-way tag store with round-robin victim and clear sweep
module cache_tag_array
  import cache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  parameter int TAG_W  = DEF_TAG_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             init_done,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_dirty,
  output logic [TAG_W-1:0] rsp_victim_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_all
);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } entry_t;

  sweep_state_e     state;
  logic [IDX_W-1:0] sweep_cnt;
  logic             sweeping;
  logic             accept;
  logic             wr_ok;

  assign init_done = (state == ST_IDLE);
  assign sweeping  = (state == ST_SWEEP) && rst_n;
  assign accept    = lk_valid && init_done && !inv_all;
  assign wr_ok     = wr_en && init_done && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SWEEP;
      sweep_cnt <= '0;
    end else begin
      case (state)
        ST_SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == IDX_W'(SETS - 1)) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (inv_all) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
          end
        end
        default: state <= ST_SWEEP;
      endcase
    end
  end

  logic [WAYS-1:0]  way_we;
  logic [IDX_W-1:0] ram_waddr;
  entry_t           ram_wdata;
  entry_t           rd [WAYS];

  always_comb begin
    way_we    = '0;
    ram_waddr = wr_index;
    ram_wdata = '{valid: wr_valid, dirty: wr_dirty, tag: wr_tag};
    if (sweeping) begin
      way_we    = '1;
      ram_waddr = sweep_cnt;
      ram_wdata = '0;
    end else begin
      for (int w = 0; w < WAYS; w++) way_we[w] = wr_ok && (wr_way == WAY_W'(w));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_tag_way_ram #(
      .DEPTH(SETS),
      .DW   (TAG_W + 2)
    ) u_ram (
      .clk  (clk),
      .we   (way_we[g]),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr(lk_index),
      .rdata(rd[g])
    );
  end

  // Round-robin pointer only advances when the pointed-at way is refilled valid.
  logic [WAY_W-1:0] rr_mem [SETS];
  logic [WAY_W-1:0] rr_q;
  logic [WAY_W-1:0] rr_cur;
  logic [WAY_W-1:0] rr_inc;

  assign rr_cur = rr_mem[wr_index];
  assign rr_inc = (WAYS == 1) ? '0 : rr_cur + 1'b1;

  always_ff @(posedge clk) begin
    rr_q <= rr_mem[lk_index];
    if (sweeping) rr_mem[sweep_cnt] <= '0;
    else if (wr_ok && wr_valid && wr_way == rr_cur) rr_mem[wr_index] <= rr_inc;
  end

  logic             lk_pend;
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_pend <= 1'b0;
      tag_q   <= '0;
    end else begin
      lk_pend <= accept;
      if (accept) tag_q <= lk_tag;
    end
  end

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] sel_way;
  entry_t           sel;

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (rd[w].valid && rd[w].tag == tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!rd[w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    sel_way = hit ? hit_way : (inv_found ? inv_way : rr_q);
    sel     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (sel_way == WAY_W'(w)) sel = rd[w];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_way        <= '0;
      rsp_dirty      <= 1'b0;
      rsp_victim_tag <= '0;
    end else begin
      rsp_valid <= lk_pend;
      if (lk_pend) begin
        rsp_hit        <= hit;
        rsp_way        <= sel_way;
        rsp_dirty      <= sel.dirty;
        rsp_victim_tag <= sel.tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_array.sv
// tb/tb_cache_tag_array.sv - self-checking bench for cache_tag_array
module tb_cache_tag_array;

  localparam int SETS  = 1024;
  localparam int WAYS  = 2;
  localparam int TAG_W = 18;
  localparam int IDX_W = 10;
  localparam int WAY_W = 1;

  logic             clk;
  logic             rst_n;
  logic             init_done;
  logic             lk_valid;
  logic [IDX_W-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_dirty;
  logic [TAG_W-1:0] rsp_victim_tag;
  logic             wr_en;
  logic [IDX_W-1:0] wr_index;
  logic [WAY_W-1:0] wr_way;
  logic             wr_valid;
  logic             wr_dirty;
  logic [TAG_W-1:0] wr_tag;
  logic             inv_all;

  cache_tag_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .lk_valid(lk_valid), .lk_index(lk_index), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_dirty(rsp_dirty), .rsp_victim_tag(rsp_victim_tag),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
    .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_tag(wr_tag),
    .inv_all(inv_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             dirty;
    logic [TAG_W-1:0] vtag;
  } exp_t;

  typedef struct packed {
    logic             is_wr;
    int               idx;
    int               way;
    logic             v;
    logic             d;
    logic [TAG_W-1:0] tag;
    logic             e_hit;
    int               e_way;
    logic             e_dirty;
    logic [TAG_W-1:0] e_vtag;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t wr_v(int i, int w, logic v, logic d, logic [TAG_W-1:0] t);
    vec_t r;
    r = '0;
    r.is_wr = 1'b1; r.idx = i; r.way = w; r.v = v; r.d = d; r.tag = t;
    return r;
  endfunction

  function automatic vec_t lk_v(int i, logic [TAG_W-1:0] t, logic h, int w, logic d,
                                logic [TAG_W-1:0] vt);
    vec_t r;
    r = '0;
    r.idx = i; r.tag = t; r.e_hit = h; r.e_way = w; r.e_dirty = d; r.e_vtag = vt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    lk_valid = 1'b0;
    wr_en    = 1'b0;
    inv_all  = 1'b0;
  endtask

  task automatic do_wr(input int i, input int w, input logic v, input logic d,
                       input logic [TAG_W-1:0] t);
    wr_en = 1'b1; wr_index = IDX_W'(i); wr_way = WAY_W'(w);
    wr_valid = v; wr_dirty = d; wr_tag = t;
  endtask

  task automatic do_lk(input int i, input logic [TAG_W-1:0] t, input logic push,
                       input logic h, input int w, input logic d, input logic [TAG_W-1:0] vt);
    exp_t e;
    lk_valid = 1'b1; lk_index = IDX_W'(i); lk_tag = t;
    if (push) begin
      e.hit = h; e.way = WAY_W'(w); e.dirty = d; e.vtag = vt;
      sb.push_back(e);
    end
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 4000) begin
      n++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      exp_t a, e;
      a = {rsp_hit, rsp_way, rsp_dirty, rsp_victim_tag};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got hit=%0b way=%0d dirty=%0b vtag=%h, required no response",
                 a.hit, a.way, a.dirty, a.vtag);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL rsp_compare: got hit=%0b way=%0d dirty=%0b vtag=%h, required hit=%0b way=%0d dirty=%0b vtag=%h",
                   a.hit, a.way, a.dirty, a.vtag, e.hit, e.way, e.dirty, e.vtag);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic low;
    rst_n = 1'b0; lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
    wr_en = 1'b0; wr_index = '0; wr_way = '0; wr_valid = 1'b0; wr_dirty = 1'b0;
    wr_tag = '0; inv_all = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    chk("rst_rsp_way", 32'(rsp_way), 0);
    chk("rst_rsp_dirty", 32'(rsp_dirty), 0);
    chk("rst_rsp_victim_tag", 32'(rsp_victim_tag), 0);

    rst_n = 1'b1;
    count_sweep(n);
    chk("reset_sweep_len", n, SETS);

    vecs.push_back(lk_v(5, 'h3, 0, 0, 0, 'h0));
    vecs.push_back(wr_v(7, 0, 1, 1, 'h11));
    vecs.push_back(wr_v(7, 1, 1, 0, 'h22));
    vecs.push_back(lk_v(7, 'h22, 1, 1, 0, 'h22));
    vecs.push_back(lk_v(7, 'h11, 1, 0, 1, 'h11));
    vecs.push_back(lk_v(7, 'h33, 0, 0, 1, 'h11));
    vecs.push_back(wr_v(7, 0, 1, 0, 'h33));
    vecs.push_back(lk_v(7, 'h44, 0, 1, 0, 'h22));
    vecs.push_back(lk_v(7, 'h33, 1, 0, 0, 'h33));
    vecs.push_back(wr_v(9, 0, 1, 0, 'h55));
    vecs.push_back(lk_v(9, 'h66, 0, 1, 0, 'h0));
    vecs.push_back(wr_v(9, 1, 0, 1, 'h77));
    vecs.push_back(lk_v(9, 'h77, 0, 1, 1, 'h77));
    vecs.push_back(wr_v(1023, 1, 1, 1, 'h3FFFF));
    vecs.push_back(lk_v(1023, 'h3FFFF, 1, 1, 1, 'h3FFFF));
    vecs.push_back(lk_v(1023, 'h0, 0, 0, 0, 'h0));

    foreach (vecs[k]) begin
      tick();
      if (vecs[k].is_wr)
        do_wr(vecs[k].idx, vecs[k].way, vecs[k].v, vecs[k].d, vecs[k].tag);
      else
        do_lk(vecs[k].idx, vecs[k].tag, 1'b1, vecs[k].e_hit, vecs[k].e_way,
              vecs[k].e_dirty, vecs[k].e_vtag);
    end

    // Same-cycle write and lookup on one set: lookup sees the old contents.
    tick();
    do_wr(3, 0, 1, 0, 'h5);
    do_lk(3, 'h5, 1'b1, 0, 0, 0, 'h0);
    tick();
    do_lk(3, 'h5, 1'b1, 1, 0, 0, 'h5);

    // Invalidate-all with one lookup in flight and one colliding with the pulse.
    tick();
    do_lk(7, 'h33, 1'b1, 1, 0, 0, 'h33);
    tick();
    inv_all = 1'b1;
    do_lk(7, 'h33, 1'b0, 0, 0, 0, 'h0);
    tick();
    n = 0;
    while (init_done !== 1'b1 && n < 4000) begin
      n++;
      if (n == 20) do_wr(7, 0, 1, 1, 'h33);
      if (n == SETS) do_wr(5, 0, 1, 0, 'h3);
      tick();
    end
    chk("inv_sweep_len", n, SETS);
    do_lk(7, 'h33, 1'b1, 0, 0, 0, 'h0);
    tick();
    do_lk(5, 'h3, 1'b1, 0, 0, 0, 'h0);
    tick();
    do_lk(1023, 'h3FFFF, 1'b1, 0, 0, 0, 'h0);
    repeat (3) tick();

    // Reset with a lookup in flight, then reset again in the middle of the sweep.
    do_lk(7, 'h0, 1'b0, 0, 0, 0, 'h0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_inflight_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_inflight_init_done", 32'(init_done), 0);
    tick();
    rst_n = 1'b1;
    low = 1'b1;
    repeat (500) begin
      if (init_done !== 1'b0) low = 1'b0;
      tick();
    end
    chk("mid_sweep_init_done_low", 32'(low), 1);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    count_sweep(n);
    chk("mid_sweep_restart_len", n, SETS);

    do_wr(7, 1, 1, 1, 'h1234);
    tick();
    do_lk(7, 'h1234, 1'b1, 1, 1, 1, 'h1234);
    tick();
    do_lk(7, 'h9, 1'b1, 0, 0, 0, 'h0);
    repeat (4) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
